// File: rtl/score_tally.sv
// score_tally: turns the per-dropper hit/miss level vectors into the HUD
// figures (score, hit/miss counts, current and best combo) and tracks the
// round state from the keyboard (0x2C starts a round, 0x01 returns to idle).
//
// Optional build macro: COMBO_BONUS_EN. When defined, a frame whose combo
// reaches BONUS_THRESH scores double points for each of that frame's hits.
//
// Ports:
//   frame_clk  in   frame-rate clock, all state updates on its rising edge
//   Reset      in   asynchronous active-high reset
//   keycode    in   primary USB keycode
//   hit_in     in   per-dropper hit level (NUM_DROPS bits)
//   miss_in    in   per-dropper miss level (NUM_DROPS bits)
//   score      out  running score, binary, clamped to SCORE_MAX
//   hit_count  out  hits this round, saturating at 255
//   miss_count out  misses this round, saturating at 255
//   combo      out  current consecutive-hit count, saturating at 255
//   max_combo  out  best combo this round
//   playing    out  high while in PLAY
//   game_over  out  high while in DONE
module score_tally #(
    parameter int unsigned NUM_DROPS    = 32,
    parameter int unsigned POINTS       = 10,
    parameter int unsigned SCORE_MAX    = 9999,
    parameter int unsigned BONUS_THRESH = 5
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic [7:0]           keycode,
    input  logic [NUM_DROPS-1:0] hit_in,
    input  logic [NUM_DROPS-1:0] miss_in,
    output logic [15:0]          score,
    output logic [7:0]           hit_count,
    output logic [7:0]           miss_count,
    output logic [7:0]           combo,
    output logic [7:0]           max_combo,
    output logic                 playing,
    output logic                 game_over
);

    localparam int unsigned CW        = $clog2(NUM_DROPS + 1);
    localparam logic [7:0]  KEY_START = 8'h2C;
    localparam logic [7:0]  KEY_IDLE  = 8'h01;

    // Reject configurations the fixed-width outputs cannot represent.
    if (NUM_DROPS == 0 || SCORE_MAX > 65535 || BONUS_THRESH > 255) begin : g_bad_params
        $error("score_tally: unsupported parameter values");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [NUM_DROPS-1:0] r_hit_q;
    logic [NUM_DROPS-1:0] r_miss_q;
    logic [15:0]          r_score;
    logic [7:0]           r_hit_count;
    logic [7:0]           r_miss_count;
    logic [7:0]           r_combo;
    logic [7:0]           r_max_combo;
    logic                 r_playing;
    logic                 r_game_over;

    logic [NUM_DROPS-1:0] w_rise_h;
    logic [NUM_DROPS-1:0] w_rise_m;
    logic [CW-1:0]        w_nh;
    logic [CW-1:0]        w_nm;
    logic [7:0]           w_combo_base;
    logic [7:0]           w_combo_next;
    logic [7:0]           w_max_next;
    logic [7:0]           w_hit_next;
    logic [7:0]           w_miss_next;
    logic [19:0]          w_pts;
    logic [19:0]          w_score_sum;
    logic [15:0]          w_score_next;
    logic                 w_all_resolved;

    function automatic logic [7:0] sat8(input logic [15:0] v);
        return (v > 16'd255) ? 8'hFF : v[7:0];
    endfunction

    // A lane raising hit and miss together is a hit only, so miss is masked
    // by the live hit level rather than by the registered one.
    always_comb begin
        w_rise_h = hit_in & ~r_hit_q;
        w_rise_m = miss_in & ~r_miss_q & ~hit_in;
        w_nh     = '0;
        w_nm     = '0;
        for (int unsigned i = 0; i < NUM_DROPS; i++) begin
            w_nh = w_nh + CW'(w_rise_h[i]);
            w_nm = w_nm + CW'(w_rise_m[i]);
        end
    end

    // Misses in a frame break the combo before that frame's hits are added.
    always_comb begin
        w_combo_base = (w_nm != '0) ? '0 : r_combo;
        w_combo_next = sat8(16'(w_combo_base) + 16'(w_nh));
        w_max_next   = (w_combo_next > r_max_combo) ? w_combo_next : r_max_combo;
        w_hit_next   = sat8(16'(r_hit_count) + 16'(w_nh));
        w_miss_next  = sat8(16'(r_miss_count) + 16'(w_nm));
`ifdef COMBO_BONUS_EN
        w_pts = (32'(w_combo_next) >= BONUS_THRESH) ? 20'(2 * POINTS) : 20'(POINTS);
`else
        w_pts = 20'(POINTS);
`endif
        w_score_sum  = 20'(r_score) + 20'(w_nh) * w_pts;
        w_score_next = (w_score_sum > 20'(SCORE_MAX)) ? 16'(SCORE_MAX) : w_score_sum[15:0];
    end

    assign w_all_resolved = &(hit_in | miss_in);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (keycode == KEY_START) begin
                    w_state_next = S_PLAY;
                end
            end
            S_PLAY: begin
                if (keycode == KEY_IDLE) begin
                    w_state_next = S_IDLE;
                end else if (w_all_resolved) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (keycode == KEY_IDLE) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Counters clear on the edge that enters IDLE, so a same-frame rising hit
    // alongside 0x01 is discarded; DONE simply holds them.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_hit_q      <= '0;
            r_miss_q     <= '0;
            r_score      <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_combo      <= '0;
            r_max_combo  <= '0;
            r_playing    <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_hit_q     <= hit_in;
            r_miss_q    <= miss_in;
            r_playing   <= (w_state_next == S_PLAY);
            r_game_over <= (w_state_next == S_DONE);
            if (w_state_next == S_IDLE) begin
                r_score      <= '0;
                r_hit_count  <= '0;
                r_miss_count <= '0;
                r_combo      <= '0;
                r_max_combo  <= '0;
            end else if (r_state == S_PLAY) begin
                r_score      <= w_score_next;
                r_hit_count  <= w_hit_next;
                r_miss_count <= w_miss_next;
                r_combo      <= w_combo_next;
                r_max_combo  <= w_max_next;
            end
        end
    end

    assign score      = r_score;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
    assign combo      = r_combo;
    assign max_combo  = r_max_combo;
    assign playing    = r_playing;
    assign game_over  = r_game_over;

endmodule

// File: tb/tb_score_tally.sv
module tb_score_tally;

`ifdef COMBO_BONUS_EN
    localparam int unsigned PTS_HI = 20;
`else
    localparam int unsigned PTS_HI = 10;
`endif
    // Number of 31-hit frames that lands exactly on 9920 before the clamp.
    localparam int unsigned K_EDGE = 9920 / (31 * PTS_HI);
    localparam logic [31:0] LANES31 = 32'h7FFF_FFFF;

    logic        frame_clk = 1'b0;
    logic        Reset;
    logic [7:0]  keycode;
    logic [31:0] hit_in;
    logic [31:0] miss_in;
    logic [15:0] score;
    logic [7:0]  hit_count;
    logic [7:0]  miss_count;
    logic [7:0]  combo;
    logic [7:0]  max_combo;
    logic        playing;
    logic        game_over;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    score_tally #(
        .NUM_DROPS    (32),
        .POINTS       (10),
        .SCORE_MAX    (9999),
        .BONUS_THRESH (5)
    ) dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .keycode    (keycode),
        .hit_in     (hit_in),
        .miss_in    (miss_in),
        .score      (score),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .combo      (combo),
        .max_combo  (max_combo),
        .playing    (playing),
        .game_over  (game_over)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int unsigned sc, input int unsigned hc,
                           input int unsigned mc, input int unsigned cb, input int unsigned mx,
                           input int unsigned pl, input int unsigned go);
        chk({tag, ".score"},      score,      sc);
        chk({tag, ".hit_count"},  hit_count,  hc);
        chk({tag, ".miss_count"}, miss_count, mc);
        chk({tag, ".combo"},      combo,      cb);
        chk({tag, ".max_combo"},  max_combo,  mx);
        chk({tag, ".playing"},    playing,    pl);
        chk({tag, ".game_over"},  game_over,  go);
    endtask

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    initial begin
        int unsigned exp_sc;
        Reset   = 1'b1;
        keycode = 8'h00;
        hit_in  = '0;
        miss_in = '0;
        #12;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        Reset = 1'b0;
        step();
        chk_all("idle", 0, 0, 0, 0, 0, 0, 0);

        // Start, then one lane held high for three frames counts once.
        keycode = 8'h2C;
        step();
        chk_all("start", 0, 0, 0, 0, 0, 1, 0);
        keycode = 8'h00;
        hit_in  = 32'h1;
        step();
        chk_all("hit0_f1", 10, 1, 0, 1, 1, 1, 0);
        step();
        step();
        chk_all("hit0_f3", 10, 1, 0, 1, 1, 1, 0);

        // Fresh round: four lanes rising together.
        keycode = 8'h01;
        hit_in  = '0;
        step();
        chk_all("abort", 0, 0, 0, 0, 0, 0, 0);
        keycode = 8'h2C;
        step();
        keycode = 8'h00;
        hit_in  = 32'hF;
        step();
        chk_all("hit4", 40, 4, 0, 4, 4, 1, 0);

        // Miss on lane 5 and hit on lane 6 in the same frame.
        hit_in  = 32'h4F;
        miss_in = 32'h20;
        step();
        chk_all("miss_hit", 50, 5, 1, 1, 4, 1, 0);

        // Lane 7 raises hit and miss together: hit only.
        hit_in  = 32'hCF;
        miss_in = 32'hA0;
        step();
        chk_all("both_lane", 60, 6, 1, 2, 4, 1, 0);

        // Lane 0 drops then re-rises: counts again.
        hit_in = 32'hCE;
        step();
        chk_all("drop0", 60, 6, 1, 2, 4, 1, 0);
        hit_in = 32'hCF;
        step();
        chk_all("rerise0", 70, 7, 1, 3, 4, 1, 0);

        // Combo 4 then one more hit reaching the bonus threshold.
        hit_in = 32'h2CF;
        step();
        chk_all("combo4", 80, 8, 1, 4, 4, 1, 0);
        hit_in = 32'h6CF;
        step();
        chk_all("combo5", 80 + PTS_HI, 9, 1, 5, 5, 1, 0);

        // 0x01 together with a rising hit: back to idle, hit discarded.
        keycode = 8'h01;
        hit_in  = 32'hECF;
        step();
        chk_all("esc_hit", 0, 0, 0, 0, 0, 0, 0);

        // Saturation round: 31 lanes pulse repeatedly.
        keycode = 8'h00;
        hit_in  = '0;
        miss_in = '0;
        step();
        keycode = 8'h2C;
        step();
        keycode = 8'h00;
        for (int unsigned k = 1; k <= K_EDGE + 2; k++) begin
            hit_in = LANES31;
            step();
            exp_sc = k * 31 * PTS_HI;
            if (exp_sc > 9999) exp_sc = 9999;
            if (k >= K_EDGE) chk($sformatf("sat_score_k%0d", k), score, exp_sc);
            hit_in = '0;
            step();
        end
        chk_all("sat", 9999, 255, 0, 255, 255, 1, 0);

        // Resolve the last lane by a miss: DONE on the same edge.
        hit_in  = LANES31;
        miss_in = 32'h8000_0000;
        step();
        chk_all("done", 9999, 255, 1, 31, 255, 0, 1);

        // DONE freezes counters and ignores 0x2C.
        hit_in = '0;
        step();
        hit_in  = LANES31;
        keycode = 8'h2C;
        step();
        chk_all("frozen", 9999, 255, 1, 31, 255, 0, 1);

        keycode = 8'h01;
        step();
        chk_all("done_esc", 0, 0, 0, 0, 0, 0, 0);

        // Stale levels still high on restart must not count.
        keycode = 8'h2C;
        step();
        chk_all("restart", 0, 0, 0, 0, 0, 1, 0);
        keycode = 8'h00;
        step();
        chk_all("stale", 0, 0, 0, 0, 0, 0, 1);

        // Asynchronous reset mid-frame.
        keycode = 8'h01;
        hit_in  = '0;
        miss_in = '0;
        step();
        keycode = 8'h2C;
        step();
        keycode = 8'h00;
        hit_in  = 32'h1;
        step();
        chk("pre_reset.score", score, 10);
        #2;
        Reset = 1'b1;
        #1;
        chk_all("async_reset", 0, 0, 0, 0, 0, 0, 0);
        #1;
        Reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/score_tally.md
Name: score_tally

Overview:
- Downstream consumer of the per-drop dropper stages.
- Collects every dropper's hit level (scoreNN) and miss level (finish without hit) as bit vectors.
- Converts them into one running score, a hit/miss count, a current combo and a best combo for the HUD and text-drawing logic.
- Tracks round state from the same keyboard keycodes the droppers use: 0x2C start, 0x01 back to idle.

Parameters:
NUM_DROPS, 32, number of dropper instances / width of hit and miss vectors
POINTS, 10, points added per hit
SCORE_MAX, 9999, score saturation ceiling (fits 4 BCD digits downstream)
BONUS_THRESH, 5, combo value at or above which bonus applies (COMBO_BONUS_EN only)

Ports:
frame_clk  input  1  frame-rate clock, all state updates on posedge
Reset  input  1  asynchronous, active-high reset
keycode  input  8  primary keycode from USB keyboard
hit_in  input  NUM_DROPS  per-dropper hit level; stays 1 after hit until that dropper halts
miss_in  input  NUM_DROPS  per-dropper miss level; stays 1 after arrow passes Y_Max unhit
score  output  16  running score, binary
hit_count  output  8  hits this round
miss_count  output  8  misses this round
combo  output  8  current consecutive-hit count
max_combo  output  8  best combo this round
playing  output  1  1 while in PLAY
game_over  output  1  1 while in DONE

Behaviour:
- Reset, asynchronous: state IDLE; all outputs 0; edge-detect registers hit_q and miss_q = 0.
- States:
  - IDLE: all counters held at 0. hit_q and miss_q are loaded with the current inputs every frame, so stale levels from the previous round never count. keycode==0x2C -> PLAY next frame.
  - PLAY: tally every frame (below). keycode==0x01 -> IDLE, which clears counters on entry. Else if every lane is resolved, i.e. (hit_in|miss_in) all ones -> DONE.
  - DONE: all counters frozen. keycode==0x01 -> IDLE. 0x2C is ignored.
- Tally in PLAY, per frame:
  - rise_h = hit_in & ~hit_q.
  - rise_m = miss_in & ~miss_q & ~hit_in. A lane asserting both counts as a hit only.
  - nh = popcount(rise_h); nm = popcount(rise_m).
  - hit_q and miss_q update to the inputs every frame.
- Ordering within one frame: misses first, then hits.
  - combo_next = (nm!=0 ? 0 : combo) + nh, saturating at 255.
  - max_combo = max(max_combo, combo_next).
- Counts: hit_count += nh; miss_count += nm; both saturate at 255.
- Score: score += nh*POINTS. Compute in 20 bits, then clamp to SCORE_MAX. The score never wraps.
- Latency: one frame_clk edge from input rise to updated outputs. playing and game_over are registered and change on the same edge as the state.
- Boundaries:
  - A level held high across frames counts once.
  - An input dropping and re-rising within PLAY counts again; this is legal because the dropper was restarted.
  - Reset asserted mid-round clears everything immediately, asynchronously.
  - Keycode 0x01 in the same frame as a rising hit: the transition to IDLE wins and the hit is discarded.

Optional Feature:
Macro COMBO_BONUS_EN.
- Defined: per frame, if combo_next >= BONUS_THRESH, each of that frame's nh hits scores 2*POINTS instead of POINTS. Same 20-bit clamp to SCORE_MAX applies.
- Undefined: every hit scores POINTS; BONUS_THRESH is unused; no bonus logic is synthesised.

Test Plan:
1. Reset, then 0x2C, then raise hit_in[0] for 3 frames -> playing=1, score=10, hit_count=1, combo=1 (counted once).
2. In PLAY, raise hit_in[3:0] in the same frame -> score=40, combo=4, max_combo=4.
3. Combo 4, then a frame with miss_in[5] and hit_in[6] rising together -> combo=1, miss_count=1, max_combo=4, score +10.
4. Preload score=9995, one hit -> score=9999; a further hit -> score stays 9999.
5. Drive all 32 lanes resolved -> game_over=1, playing=0. Keycode 0x01 -> IDLE, all counters 0. Inputs still high, then 0x2C -> no spurious counts.
6. With COMBO_BONUS_EN and combo=4, one hit -> combo=5, score +20. Without the macro -> score +10. Assert Reset mid-frame -> outputs 0 before the next edge.
